// File: rtl/ans_renorm_unit.sv
// ANS decoder state / renormalisation unit.
// Bitstream words are queued in a small FIFO, unpacked MSB-first into
// RENORM_BITS chunks, and shifted into the decoder state until it is back
// in [LOWER_BOUND, 2^STATE_WIDTH). The initial state can also be loaded
// from the stream on request.
module ans_renorm_unit #(
  parameter int unsigned             STATE_WIDTH = 32,
  parameter int unsigned             WORD_WIDTH  = 32,
  parameter int unsigned             RENORM_BITS = 16,
  parameter int unsigned             FIFO_DEPTH  = 8,
  parameter logic [STATE_WIDTH-1:0]  LOWER_BOUND = STATE_WIDTH'(32'h0001_0000)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WORD_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             init_req,
  input  logic                             upd_valid,
  input  logic [STATE_WIDTH-1:0]           upd_state,
  output logic                             upd_ready,
  output logic [STATE_WIDTH-1:0]           state_out,
  output logic                             state_valid,
  output logic                             starved,
  output logic                             renorm_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int unsigned PtrW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW          = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ChunksPerWord = WORD_WIDTH / RENORM_BITS;
  localparam int unsigned StepsPerState = STATE_WIDTH / RENORM_BITS;
  localparam int unsigned CntW          = $clog2(ChunksPerWord + 1);
  localparam int unsigned StepW         = $clog2(StepsPerState + 1);

  typedef enum logic [1:0] {
    StReady,
    StRenorm,
    StInitLoad
  } fsm_e;

  // ---------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;

  // ---------------------------------------------------------------------
  // Unpack buffer: the word is kept left-aligned, so the next chunk is
  // always its top RENORM_BITS bits.
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0]  buf_word_q, buf_word_d;
  logic [CntW-1:0]        buf_left_q, buf_left_d;
  logic                   chunk_avail;
  logic [RENORM_BITS-1:0] chunk;
  logic                   take_chunk;

  // ---------------------------------------------------------------------
  // Decoder state and control
  // ---------------------------------------------------------------------
  fsm_e                   fsm_q, fsm_d;
  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [StepW-1:0]       steps_q, steps_d;
  logic [StepW-1:0]       steps_inc;
  logic                   last_step;
  logic [STATE_WIDTH-1:0] shifted;

  assign in_ready   = (level_q != LvlW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign fifo_push  = in_valid && in_ready;
  // Refill only once the buffer is fully drained; this costs one bubble
  // per word but keeps the FIFO read off the shift path.
  assign fifo_pop   = !chunk_avail && !fifo_empty;
  assign fifo_level = level_q;

  assign chunk_avail = (buf_left_q != '0);
  assign chunk       = buf_word_q[WORD_WIDTH-1 -: RENORM_BITS];
  assign take_chunk  = (fsm_q != StReady) && chunk_avail;

  assign shifted   = STATE_WIDTH'({state_q, chunk});
  assign steps_inc = steps_q + StepW'(1);
  assign last_step = (steps_inc == StepW'(StepsPerState));

  assign upd_ready   = (fsm_q == StReady) && !init_req;
  assign starved     = (fsm_q != StReady) && !chunk_avail;
  assign state_out   = state_q;
  assign state_valid = valid_q;
  assign renorm_err  = err_q;

  // FIFO pointer and level next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Unpack buffer next-state: refill and chunk consumption never coincide.
  always_comb begin
    buf_word_d = buf_word_q;
    buf_left_d = buf_left_q;
    if (fifo_pop) begin
      buf_word_d = mem_q[rd_ptr_q];
      buf_left_d = CntW'(ChunksPerWord);
    end else if (take_chunk) begin
      buf_word_d = buf_word_q << RENORM_BITS;
      buf_left_d = buf_left_q - CntW'(1);
    end
  end

  // Control FSM next-state.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    valid_d = valid_q;
    err_d   = err_q;
    steps_d = steps_q;
    unique case (fsm_q)
      StReady: begin
        if (init_req) begin
          fsm_d   = StInitLoad;
          state_d = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
          steps_d = '0;
        end else if (upd_valid) begin
          state_d = upd_state;
          if (upd_state < LOWER_BOUND) begin
            fsm_d   = StRenorm;
            valid_d = 1'b0;
            steps_d = '0;
          end
        end
      end
      StRenorm: begin
        if (chunk_avail) begin
          state_d = shifted;
          steps_d = steps_inc;
          if (shifted >= LOWER_BOUND) begin
            fsm_d   = StReady;
            valid_d = 1'b1;
          end else if (last_step) begin
            // State could not be normalised within one full state width.
            fsm_d   = StReady;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      StInitLoad: begin
        if (chunk_avail) begin
          state_d = shifted;
          steps_d = steps_inc;
          if (last_step) begin
            fsm_d   = StReady;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        fsm_d   = StReady;
        valid_d = 1'b1;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      buf_word_q <= '0;
      buf_left_q <= '0;
      fsm_q      <= StReady;
      state_q    <= LOWER_BOUND;
      valid_q    <= 1'b1;
      err_q      <= 1'b0;
      steps_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      buf_word_q <= buf_word_d;
      buf_left_q <= buf_left_d;
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      steps_q    <= steps_d;
    end
  end

endmodule
